// File: rtl/state_sequencer.sv
// -----------------------------------------------------------------------------
// state_sequencer
//
// Multi-cycle instruction sequencer for a small RISC-V style datapath. It walks
// each instruction through fetch, decode and class-specific execute states and
// publishes the current state code for a downstream control-signal decoder.
//
// Ports
//   clk           in   1  single clock, all state updates on the rising edge
//   reset         in   1  asynchronous, active-low reset
//   opcode        in   7  instruction-register opcode field, stable from decode
//                         until the sequencer returns to fetch
//   mem_ready     in   1  memory access of the current cycle completes
//   stall         in   1  freezes the sequencer (beats mem_ready and opcode)
//   StateRegister out  4  registered current state code
//   illegal       out  1  registered sticky flag: unsupported opcode/state
//   instret       out 32  registered retired-instruction counter (wraps)
//
// All outputs come straight from flops; the next-state logic only feeds the
// flop inputs, so there is no input-to-output combinational path.
// -----------------------------------------------------------------------------
module state_sequencer (
  input  logic        clk,
  input  logic        reset,
  input  logic [6:0]  opcode,
  input  logic        mem_ready,
  input  logic        stall,
  output logic [3:0]  StateRegister,
  output logic        illegal,
  output logic [31:0] instret
);

  // Opcode classes
  localparam logic [6:0] opLoad   = 7'b0000011;
  localparam logic [6:0] opStore  = 7'b0100011;
  localparam logic [6:0] opR      = 7'b0110011;
  localparam logic [6:0] opIAlu   = 7'b0010011;
  localparam logic [6:0] opBranch = 7'b1100011;
  localparam logic [6:0] opJal    = 7'b1101111;
  localparam logic [6:0] opJalr   = 7'b1100111;
  localparam logic [6:0] opAuipc  = 7'b0010111;

  // State codes are visible to the control decoder, so the encoding is fixed.
  typedef enum logic [3:0] {
    sFetch      = 4'd0,
    sDecode     = 4'd1,
    sMemAddr    = 4'd2,
    sMemRead    = 4'd3,
    sLoadWb     = 4'd4,
    sMemWrite   = 4'd5,
    sRExec      = 4'd6,
    sAluWb      = 4'd7,
    sBranch     = 4'd8,
    sLinkSave   = 4'd9,
    sJalTarget  = 4'd10,
    sAuipc      = 4'd11,
    sJalrTarget = 4'd12,
    sIExec      = 4'd13,
    sUnused     = 4'd14,
    sHalt       = 4'd15
  } stateT;

  stateT       stateReg;
  stateT       stateNext;
  logic        illegalReg;
  logic        illegalNext;
  logic [31:0] instretReg;
  logic [31:0] instretNext;
  logic        retire;

  // ---------------------------------------------------------------------------
  // State, flag and counter registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stateReg   <= sFetch;
      illegalReg <= 1'b0;
      instretReg <= 32'd0;
    end else begin
      stateReg   <= stateNext;
      illegalReg <= illegalNext;
      instretReg <= instretNext;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state, sticky illegal flag and retire counter
  // ---------------------------------------------------------------------------
  always_comb begin
    stateNext   = stateReg;
    illegalNext = illegalReg;
    instretNext = instretReg;
    retire      = 1'b0;

    // A stall leaves every register exactly as it is.
    if (!stall) begin
      case (stateReg)
        sFetch: begin
          if (mem_ready) begin
            stateNext = sDecode;
          end
        end

        sDecode: begin
          case (opcode)
            opLoad, opStore: stateNext = sMemAddr;
            opR:             stateNext = sRExec;
            opIAlu:          stateNext = sIExec;
            opBranch:        stateNext = sBranch;
            opJal, opJalr:   stateNext = sLinkSave;
            opAuipc:         stateNext = sAuipc;
            default: begin
              stateNext   = sHalt;
              illegalNext = 1'b1;
            end
          endcase
        end

        // Only reachable with a changed opcode if the IR was not held stable;
        // treat that as an illegal instruction rather than guessing.
        sMemAddr: begin
          if (opcode == opLoad) begin
            stateNext = sMemRead;
          end else if (opcode == opStore) begin
            stateNext = sMemWrite;
          end else begin
            stateNext   = sHalt;
            illegalNext = 1'b1;
          end
        end

        sMemRead: begin
          if (mem_ready) begin
            stateNext = sLoadWb;
          end
        end

        // The store retires directly from the write state once memory accepts.
        sMemWrite: begin
          if (mem_ready) begin
            stateNext = sFetch;
            retire    = 1'b1;
          end
        end

        sRExec, sIExec: begin
          stateNext = sAluWb;
        end

        sLinkSave: begin
          if (opcode == opJal) begin
            stateNext = sJalTarget;
          end else if (opcode == opJalr) begin
            stateNext = sJalrTarget;
          end else begin
            stateNext   = sHalt;
            illegalNext = 1'b1;
          end
        end

        // Single-cycle completion states: always retire and refetch.
        sLoadWb, sAluWb, sBranch, sJalTarget, sAuipc, sJalrTarget: begin
          stateNext = sFetch;
          retire    = 1'b1;
        end

        sUnused: begin
          stateNext   = sHalt;
          illegalNext = 1'b1;
        end

        // HALT is absorbing; only reset leaves it.
        sHalt: begin
          stateNext   = sHalt;
          illegalNext = 1'b1;
        end

        default: begin
          stateNext   = sHalt;
          illegalNext = 1'b1;
        end
      endcase

      // Natural 32-bit wrap from 0xFFFFFFFF to 0.
      if (retire) begin
        instretNext = instretReg + 32'd1;
      end
    end
  end

  assign StateRegister = stateReg;
  assign illegal       = illegalReg;
  assign instret       = instretReg;

endmodule

// File: doc/state_sequencer.md
STATE_SEQUENCER -- requirements
Module: state_sequencer

Interface
REQ-001 The port clk SHALL be an input, 1 bit wide, and be the single clock; every state element updates on its rising edge.
REQ-002 The port reset SHALL be an input, 1 bit wide, and act as an asynchronous, active-low reset.
REQ-003 The port opcode SHALL be an input, 7 bits wide, carrying the instruction-register opcode field, stable from state 1 until the next return to state 0.
REQ-004 The port mem_ready SHALL be an input, 1 bit wide; high means the memory access of the current cycle completes.
REQ-005 The port stall SHALL be an input, 1 bit wide; high freezes the sequencer.
REQ-006 The port StateRegister SHALL be an output, 4 bits wide, carrying the registered current state code that feeds the control-signal decoder.
REQ-007 The port illegal SHALL be an output, 1 bit wide, and be a registered, sticky flag for an unsupported opcode or state code.
REQ-008 The port instret SHALL be an output, 32 bits wide, and be a registered retired-instruction counter.

Function
REQ-009 The state codes SHALL be: 0 fetch, 1 decode, 2 memory-address, 3 memory-read, 4 load-writeback, 5 memory-write, 6 R-execute, 7 ALU-writeback, 8 branch, 9 link-save, 10 JAL-target, 11 AUIPC, 12 JALR-target, 13 I-execute, 15 HALT; code 14 SHALL be unused.
REQ-010 The opcode classes SHALL be: LOAD 0000011, STORE 0100011, R 0110011, I-ALU 0010011, BRANCH 1100011, JAL 1101111, JALR 1100111, AUIPC 0010111.
REQ-011 State 0 SHALL go to 1 when mem_ready=1, and otherwise stay in 0.
REQ-012 State 1 SHALL go to: 2 on LOAD/STORE; 6 on R; 13 on I-ALU; 8 on BRANCH; 9 on JAL/JALR; 11 on AUIPC; 15 on any other opcode, setting illegal=1 on the same edge.
REQ-013 State 2 SHALL go to 3 on LOAD and to 5 on STORE.
REQ-014 State 3 SHALL go to 4 when mem_ready=1, and otherwise stay in 3.
REQ-015 State 5 SHALL go to 0 when mem_ready=1, and otherwise stay in 5.
REQ-016 State 6 SHALL go to 7, and state 13 SHALL go to 7.
REQ-017 State 9 SHALL go to 10 on JAL and to 12 on JALR.
REQ-018 States 4, 7, 8, 10, 11 and 12 SHALL go to 0 unconditionally.
REQ-019 An opcode in state 2 other than LOAD/STORE, or in state 9 other than JAL/JALR, SHALL send the sequencer to 15 with illegal=1.
REQ-020 Code 14 SHALL go to 15 with illegal=1.
REQ-021 State 15 SHALL be absorbing (only reset leaves it), and illegal SHALL stay 1 until reset.
REQ-022 stall=1 SHALL hold StateRegister, illegal and instret unchanged; stall SHALL take priority over mem_ready and opcode.
REQ-023 instret SHALL increment by 1 on every clock edge on which the state moves from {4, 5, 7, 8, 10, 11, 12} to 0; it SHALL wrap from 0xFFFFFFFF to 0x00000000.
REQ-024 Each instruction class SHALL complete in the following minimum cycles, with each mem_ready-low cycle in states 0, 3 or 5 adding one cycle:
- LOAD: 5
- STORE: 4
- R: 4
- I-ALU: 4
- BRANCH: 3
- JAL/JALR: 4
- AUIPC: 3
REQ-025 All outputs SHALL be driven directly from flops, with no combinational path from any input to any output.

Reset
REQ-026 While reset=0, the block SHALL hold StateRegister=0, illegal=0 and instret=0, independent of clk.
REQ-027 Reset assertion mid-instruction, including in HALT, SHALL abort the instruction immediately without incrementing instret.
REQ-028 After reset deasserts, the first rising clk edge SHALL evaluate state 0 normally.

Verification
REQ-029 LOAD with mem_ready=1 throughout: the state trace SHALL be 0,1,2,3,4,0, and instret SHALL go 0->1 on the edge into the final 0.
REQ-030 STORE with mem_ready low for 2 cycles in state 5: the trace SHALL be 0,1,2,5,5,5,0, and instret SHALL increment exactly once.
REQ-031 JALR then JAL back-to-back: the traces SHALL be 0,1,9,12,0 and then 0,1,9,10,0, with instret=2.
REQ-032 Opcode 1111111 in decode: the state SHALL be 15 on the next edge with illegal=1, and both SHALL be held for 20 cycles under changing opcode.
REQ-033 stall=1 for 3 cycles while in state 6: StateRegister SHALL stay 6 for those cycles, then go 7,0, with instret unchanged during the stall.
REQ-034 Preloaded instret=0xFFFFFFFF followed by a BRANCH: instret SHALL become 0x00000000; asserting reset in state 3 SHALL immediately force StateRegister=0, instret=0 and illegal=0.
